// File: rtl/hist_pkg.sv
// hist_pkg: shared definitions for the histogram CDF read-out engine.
//   HIST_ADDR_W / HIST_DATA_W / HIST_CDF_W : default bin address, bin count and
//                                           cumulative-sum widths
//   state_e                                : read-out FSM states
//   beat_t                                 : one output beat {bin, count, cdf, last}
// beat_t is sized from the package defaults. A build that overrides the
// top-level widths must change these defaults to match.
package hist_pkg;

  localparam int HIST_ADDR_W = 8;
  localparam int HIST_DATA_W = 20;
  localparam int HIST_CDF_W  = 28;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [HIST_ADDR_W-1:0] bin;
    logic [HIST_DATA_W-1:0] count;
    logic [HIST_CDF_W-1:0]  cdf;
    logic                   last;
  } beat_t;

endpackage

// File: rtl/hist_skid_fifo.sv
// hist_skid_fifo: 2-entry register FIFO carrying histogram beats.
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : synchronous empty (wins over push/pop)
//   push        : write push_data
//   push_data   : beat to enqueue
//   pop         : remove the head entry (ignored when empty)
//   head        : current head entry (registered, stable until popped)
//   occupancy   : number of valid entries, 0..2
module hist_skid_fifo
  import hist_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push,
  input  beat_t      push_data,
  input  logic       pop,
  output beat_t      head,
  output logic [1:0] occupancy
);

  beat_t entry1;
  logic  pop_ok;

  assign pop_ok = pop && (occupancy != 2'd0);

  // Entry 0 is always the head; a pop shifts entry 1 forward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= 2'd0;
      head      <= '0;
      entry1    <= '0;
    end else if (flush) begin
      occupancy <= 2'd0;
    end else begin
      case ({push, pop_ok})
        2'b10: begin
          if (occupancy == 2'd0) head <= push_data;
          else                   entry1 <= push_data;
          occupancy <= occupancy + 2'd1;
        end
        2'b01: begin
          head      <= entry1;
          occupancy <= occupancy - 2'd1;
        end
        2'b11: begin
          if (occupancy == 2'd1) begin
            head <= push_data;
          end else begin
            head   <= entry1;
            entry1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/hist_cdf_reader.sv
// hist_cdf_reader: sweeps the 256-bin histogram RAM and streams
// {bin, count, running CDF, last} over valid/ready.
//   iClk, iRst_n     : clock, asynchronous active-low reset
//   iStart, iAbort   : start request (IDLE only), synchronous abort
//   oReadAddr        : registered RAM read address
//   iDataIn          : RAM data, valid the cycle after the address
//   oValid, iReady   : output handshake
//   oBin, oCount, oCdf, oLast : beat payload
//   oBusy, oDone, oTotal      : status, done pulse, final CDF
// Optional feature (macro HIST_PEAK_EN): oPeakBin / oPeakCount report the
// highest-count bin of the last completed sweep (ties go to the lower bin).
module hist_cdf_reader
  import hist_pkg::*;
#(
  parameter int ADDR_W = HIST_ADDR_W,
  parameter int DATA_W = HIST_DATA_W,
  parameter int CDF_W  = HIST_CDF_W
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iStart,
  input  logic              iAbort,
  output logic [ADDR_W-1:0] oReadAddr,
  input  logic [DATA_W-1:0] iDataIn,
  output logic              oValid,
  input  logic              iReady,
  output logic [ADDR_W-1:0] oBin,
  output logic [DATA_W-1:0] oCount,
  output logic [CDF_W-1:0]  oCdf,
  output logic              oLast,
  output logic              oBusy,
  output logic              oDone,
  output logic [CDF_W-1:0]  oTotal
`ifdef HIST_PEAK_EN
  ,
  output logic [ADDR_W-1:0] oPeakBin,
  output logic [DATA_W-1:0] oPeakCount
`endif
);

  localparam logic [ADDR_W-1:0] TOP_BIN = '1;

  state_e            state;
  logic              vld_p1;
  logic [ADDR_W-1:0] bin_p1;
  logic [CDF_W-1:0]  acc;
  logic [CDF_W-1:0]  cdf_p1;
  logic [1:0]        occ;
  logic [2:0]        occ_eff;
  logic              pop;
  logic              issue;
  logic              last_hs;
  beat_t             head;
  beat_t             push_beat;

  assign pop = oValid & iReady;

  // Slots committed once this cycle's capture and pop settle. Counting the
  // pop lets a read issue every cycle while the consumer keeps up, yet never
  // lets buffered plus in-flight beats exceed the two FIFO entries.
  assign occ_eff = {1'b0, occ} + {2'b00, vld_p1} - {2'b00, pop};
  assign issue   = (state == ST_SWEEP) && (occ_eff < 3'd2);
  assign cdf_p1  = acc + CDF_W'(iDataIn);
  assign last_hs = pop & head.last;

  always_comb begin
    push_beat       = '0;
    push_beat.bin   = bin_p1;
    push_beat.count = iDataIn;
    push_beat.cdf   = cdf_p1;
    push_beat.last  = (bin_p1 == TOP_BIN);
  end

  hist_skid_fifo u_fifo (
    .clk       (iClk),
    .rst_n     (iRst_n),
    .flush     (iAbort),
    .push      (vld_p1),
    .push_data (push_beat),
    .pop       (pop),
    .head      (head),
    .occupancy (occ)
  );

  assign oValid = (occ != 2'd0);
  assign oBin   = head.bin;
  assign oCount = head.count;
  assign oCdf   = head.cdf;
  assign oLast  = head.last;

  // Stage p0: address issue / FSM.  Stage p1: capture of RAM data into the
  // accumulator and FIFO (vld_p1 marks a read whose data arrives this cycle).
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state     <= ST_IDLE;
      oReadAddr <= '0;
      vld_p1    <= 1'b0;
      bin_p1    <= '0;
      acc       <= '0;
      oBusy     <= 1'b0;
      oDone     <= 1'b0;
      oTotal    <= '0;
    end else if (iAbort) begin
      state  <= ST_IDLE;
      vld_p1 <= 1'b0;
      oBusy  <= 1'b0;
      oDone  <= 1'b0;
    end else begin
      vld_p1 <= issue;
      if (issue)  bin_p1 <= oReadAddr;
      if (vld_p1) acc <= cdf_p1;
      oDone <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (iStart) begin
            state     <= ST_SWEEP;
            oReadAddr <= '0;
            acc       <= '0;
            oBusy     <= 1'b1;
          end
        end
        ST_SWEEP: begin
          if (issue) begin
            if (oReadAddr == TOP_BIN) state <= ST_DRAIN;
            else                      oReadAddr <= oReadAddr + ADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          if (last_hs) begin
            state  <= ST_DONE;
            oDone  <= 1'b1;
            oTotal <= head.cdf;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          oBusy <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef HIST_PEAK_EN
  logic [ADDR_W-1:0] pk_bin_p1;
  logic [DATA_W-1:0] pk_cnt_p1;

  // Strict greater-than over an ascending sweep keeps the lowest tied bin.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      pk_bin_p1  <= '0;
      pk_cnt_p1  <= '0;
      oPeakBin   <= '0;
      oPeakCount <= '0;
    end else if (!iAbort) begin
      if (state == ST_IDLE && iStart) begin
        pk_bin_p1 <= '0;
        pk_cnt_p1 <= '0;
      end else if (vld_p1 && (iDataIn > pk_cnt_p1)) begin
        pk_bin_p1 <= bin_p1;
        pk_cnt_p1 <= iDataIn;
      end
      if (state == ST_DRAIN && last_hs) begin
        oPeakBin   <= pk_bin_p1;
        oPeakCount <= pk_cnt_p1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hist_cdf_reader.sv
`timescale 1ns/1ps
module tb_hist_cdf_reader;

  localparam int AW = 8;
  localparam int DW = 20;
  localparam int CW = 28;
  localparam int NB = 256;

  localparam int P_IDX  = 0;
  localparam int P_MAX  = 1;
  localparam int P_ZERO = 2;
  localparam int P_RAND = 3;
  localparam int P_PEAK = 4;

  logic          iClk = 1'b0;
  logic          iRst_n;
  logic          iStart;
  logic          iAbort;
  logic          iReady;
  logic [AW-1:0] oReadAddr;
  logic [DW-1:0] iDataIn;
  logic          oValid;
  logic [AW-1:0] oBin;
  logic [DW-1:0] oCount;
  logic [CW-1:0] oCdf;
  logic          oLast;
  logic          oBusy;
  logic          oDone;
  logic [CW-1:0] oTotal;
`ifdef HIST_PEAK_EN
  logic [AW-1:0] oPeakBin;
  logic [DW-1:0] oPeakCount;
`endif

  hist_cdf_reader dut (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .iStart    (iStart),
    .iAbort    (iAbort),
    .oReadAddr (oReadAddr),
    .iDataIn   (iDataIn),
    .oValid    (oValid),
    .iReady    (iReady),
    .oBin      (oBin),
    .oCount    (oCount),
    .oCdf      (oCdf),
    .oLast     (oLast),
    .oBusy     (oBusy),
    .oDone     (oDone),
    .oTotal    (oTotal)
`ifdef HIST_PEAK_EN
    ,
    .oPeakBin  (oPeakBin),
    .oPeakCount(oPeakCount)
`endif
  );

  always #5 iClk = ~iClk;

  // Histogram RAM: one-cycle read latency.
  logic [DW-1:0] ram [NB];
  always @(posedge iClk) iDataIn <= ram[oReadAddr];

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic [CW-1:0] exp_cdf [NB];
  logic [CW-1:0] last_total;
  logic [AW-1:0] exp_pk_bin;
  logic [DW-1:0] exp_pk_cnt;
  logic [AW-1:0] last_pk_bin;
  logic [DW-1:0] last_pk_cnt;

  typedef struct {
    int     pat;
    int     ready_pct;
    bit     glitch;
    bit     timing;
    longint exp_total;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fill_ram(input int pat);
    for (int k = 0; k < NB; k++) begin
      case (pat)
        P_IDX:   ram[k] = DW'(k);
        P_MAX:   ram[k] = 20'hFFFFF;
        P_ZERO:  ram[k] = '0;
        P_PEAK:  ram[k] = DW'($urandom_range(0, 4999));
        default: ram[k] = DW'($urandom_range(0, 32'hFFFFF));
      endcase
    end
    if (pat == P_PEAK) begin
      ram[17]  = 20'd5000;
      ram[200] = 20'd5000;
    end
  endtask

  // Prefix sums and first-maximum over the RAM image.
  task automatic build_model();
    longint acc;
    acc = 0;
    exp_pk_bin = '0;
    exp_pk_cnt = '0;
    for (int k = 0; k < NB; k++) begin
      acc = acc + longint'(ram[k]);
      exp_cdf[k] = acc[CW-1:0];
      if (ram[k] > exp_pk_cnt) begin
        exp_pk_bin = AW'(k);
        exp_pk_cnt = ram[k];
      end
    end
  endtask

  task automatic run_sweep(input int ready_pct, input int abort_at, input bit glitch,
                           input bit timing_chk, input longint exp_total_tab);
    int  beat, cyc, first_v, last_c, done_c, idle_c;
    bit  hold, aborted, dseen;
    logic [AW+DW+CW:0] held;
    build_model();
    @(posedge iClk); #1;
    iStart = 1'b1;
    iReady = 1'b0;
    @(posedge iClk); #1;
    iStart = 1'b0;
    cyc = 1; beat = 0; first_v = -1; last_c = -1; done_c = -1; idle_c = -1;
    hold = 1'b0; aborted = 1'b0; held = '0;
    chk("busy_after_start", 64'(oBusy), 64'd1);
    while (cyc < 5000) begin
      if (oValid && first_v < 0) first_v = cyc;
      if (oDone && done_c < 0) begin
        done_c = cyc;
        chk("busy_in_done", 64'(oBusy), 64'd1);
      end
      if (done_c >= 0 && !oBusy) begin
        idle_c = cyc;
        break;
      end
      if (hold) begin
        chk("stall_valid", 64'(oValid), 64'd1);
        chk("stall_payload", 64'({oBin, oCount, oCdf, oLast}), 64'(held));
      end
      if (oBusy && oReadAddr != 8'hFF)
        chk("issue_window", 64'((int'(oReadAddr) - beat) <= 2), 64'd1);
      iStart = glitch && (cyc == 50);
      if (abort_at >= 0 && beat == abort_at) begin
        iAbort = 1'b1;
        iReady = 1'b0;
        @(posedge iClk); #1;
        iAbort = 1'b0;
        chk("abort_valid", 64'(oValid), 64'd0);
        chk("abort_busy", 64'(oBusy), 64'd0);
        dseen = 1'b0;
        repeat (10) begin
          if (oDone) dseen = 1'b1;
          @(posedge iClk); #1;
        end
        chk("abort_no_done", 64'(dseen), 64'd0);
        chk("abort_total_kept", 64'(oTotal), 64'(last_total));
`ifdef HIST_PEAK_EN
        chk("abort_peak_bin_kept", 64'(oPeakBin), 64'(last_pk_bin));
        chk("abort_peak_cnt_kept", 64'(oPeakCount), 64'(last_pk_cnt));
`endif
        aborted = 1'b1;
        break;
      end
      iReady = ($urandom_range(0, 99) < ready_pct);
      if (oValid && iReady) begin
        if (beat < NB) begin
          chk("beat_bin", 64'(oBin), 64'(beat));
          chk("beat_count", 64'(oCount), 64'(ram[beat]));
          chk("beat_cdf", 64'(oCdf), 64'(exp_cdf[beat]));
          chk("beat_last", 64'(oLast), 64'(beat == NB - 1));
        end else begin
          chk("extra_beat", 64'(beat), 64'(NB - 1));
        end
        if (beat == NB - 1) last_c = cyc;
        beat++;
        hold = 1'b0;
      end else if (oValid) begin
        hold = 1'b1;
        held = {oBin, oCount, oCdf, oLast};
      end else begin
        hold = 1'b0;
      end
      @(posedge iClk); #1;
      cyc++;
    end
    iStart = 1'b0;
    iReady = 1'b0;
    if (!aborted) begin
      chk("sweep_completed_in_budget", 64'(idle_c >= 0), 64'd1);
      chk("beats_delivered", 64'(beat), 64'(NB));
      chk("done_one_cycle", 64'(oDone), 64'd0);
      chk("total_model", 64'(oTotal), 64'(exp_cdf[NB-1]));
      if (exp_total_tab >= 0) chk("total_table", 64'(oTotal), 64'(exp_total_tab));
      if (timing_chk) begin
        chk("first_valid_cycle", 64'(first_v), 64'd3);
        chk("last_beat_cycle", 64'(last_c), 64'd258);
        chk("done_cycle", 64'(done_c), 64'd259);
        chk("busy_low_cycle", 64'(idle_c), 64'd260);
      end
      last_total = exp_cdf[NB-1];
      last_pk_bin = exp_pk_bin;
      last_pk_cnt = exp_pk_cnt;
`ifdef HIST_PEAK_EN
      chk("peak_bin", 64'(oPeakBin), 64'(exp_pk_bin));
      chk("peak_cnt", 64'(oPeakCount), 64'(exp_pk_cnt));
`endif
    end
  endtask

  initial begin
    vecs[0] = '{P_IDX,  100, 1'b0, 1'b1, longint'(32640)};
    vecs[1] = '{P_MAX,  100, 1'b0, 1'b1, longint'(268435200)};
    vecs[2] = '{P_IDX,   30, 1'b0, 1'b0, longint'(32640)};
    vecs[3] = '{P_RAND,  30, 1'b1, 1'b0, longint'(-1)};
    vecs[4] = '{P_ZERO,  70, 1'b0, 1'b0, longint'(0)};
    vecs[5] = '{P_PEAK, 100, 1'b0, 1'b1, longint'(-1)};
    vecs[6] = '{P_RAND,  55, 1'b1, 1'b0, longint'(-1)};

    iRst_n = 1'b0;
    iStart = 1'b0;
    iAbort = 1'b0;
    iReady = 1'b0;
    last_total  = '0;
    last_pk_bin = '0;
    last_pk_cnt = '0;
    fill_ram(P_ZERO);
    repeat (3) @(posedge iClk);
    #1;
    iRst_n = 1'b1;
    @(posedge iClk); #1;
    chk("rst_valid", 64'(oValid), 64'd0);
    chk("rst_busy", 64'(oBusy), 64'd0);
    chk("rst_done", 64'(oDone), 64'd0);
    chk("rst_total", 64'(oTotal), 64'd0);
    chk("rst_addr", 64'(oReadAddr), 64'd0);
`ifdef HIST_PEAK_EN
    chk("rst_peak_bin", 64'(oPeakBin), 64'd0);
    chk("rst_peak_cnt", 64'(oPeakCount), 64'd0);
`endif

    for (int v = 0; v < 7; v++) begin
      fill_ram(vecs[v].pat);
      run_sweep(vecs[v].ready_pct, -1, vecs[v].glitch, vecs[v].timing, vecs[v].exp_total);
`ifdef HIST_PEAK_EN
      if (vecs[v].pat == P_PEAK) begin
        chk("peak_tie_bin", 64'(oPeakBin), 64'd17);
        chk("peak_tie_cnt", 64'(oPeakCount), 64'd5000);
      end
`endif
    end

    // Abort at beat 100, then a full sweep must follow.
    fill_ram(P_RAND);
    run_sweep(80, 100, 1'b0, 1'b0, longint'(-1));
    run_sweep(100, -1, 1'b0, 1'b1, longint'(-1));

    // Start and abort together in IDLE: abort wins.
    @(posedge iClk); #1;
    iStart = 1'b1;
    iAbort = 1'b1;
    @(posedge iClk); #1;
    iStart = 1'b0;
    iAbort = 1'b0;
    chk("start_abort_busy", 64'(oBusy), 64'd0);
    @(posedge iClk); #1;
    chk("start_abort_busy_later", 64'(oBusy), 64'd0);
    chk("start_abort_valid", 64'(oValid), 64'd0);

    // Asynchronous reset in the middle of a sweep.
    fill_ram(P_IDX);
    @(posedge iClk); #1;
    iStart = 1'b1;
    @(posedge iClk); #1;
    iStart = 1'b0;
    iReady = 1'b1;
    repeat (60) @(posedge iClk);
    #3;
    iRst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(oValid), 64'd0);
    chk("arst_busy", 64'(oBusy), 64'd0);
    chk("arst_done", 64'(oDone), 64'd0);
    chk("arst_addr", 64'(oReadAddr), 64'd0);
    chk("arst_payload", 64'({oBin, oCount, oCdf, oLast}), 64'd0);
    chk("arst_total", 64'(oTotal), 64'd0);
`ifdef HIST_PEAK_EN
    chk("arst_peak_bin", 64'(oPeakBin), 64'd0);
    chk("arst_peak_cnt", 64'(oPeakCount), 64'd0);
`endif
    last_total  = '0;
    last_pk_bin = '0;
    last_pk_cnt = '0;
    iReady = 1'b0;
    @(posedge iClk); #1;
    iRst_n = 1'b1;
    fill_ram(P_RAND);
    run_sweep(60, -1, 1'b0, 1'b0, longint'(-1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hist_cdf_reader.md
# hist_cdf_reader

Sequential read-out engine for the 256-bin grey-level histogram RAM. On a start pulse it sweeps every bin address in order, absorbs the RAM's one-cycle read latency, and streams bin index, bin count and running cumulative sum (CDF) over a valid/ready interface. Downstream consumers are the equalisation-LUT builder and the debug/VGA overlay. It occupies the RAM read port while the histogram writer is idle, and raises `oBusy` so the frame controller can hold off writes and clears.

## Interface
- `ADDR_W`, 8, bin address width; bins = 2^ADDR_W
- `DATA_W`, 20, bin count width (matches RAM word)
- `CDF_W`, 28, cumulative width; must be ≥ DATA_W+ADDR_W
- `iClk` in 1: single clock, all logic on rising edge
- `iRst_n` in 1: asynchronous, active-low reset
- `iStart` in 1: one-cycle start request; ignored unless IDLE
- `iAbort` in 1: synchronous abort; flushes the block and returns to IDLE
- `oReadAddr` out ADDR_W: RAM read address (registered)
- `iDataIn` in DATA_W: RAM read data, valid the cycle after the address
- `oValid` out 1: output beat valid
- `iReady` in 1: downstream accept
- `oBin` out ADDR_W: bin index of the current beat
- `oCount` out DATA_W: bin count
- `oCdf` out CDF_W: sum of counts for bins 0..oBin inclusive
- `oLast` out 1: beat is bin 2^ADDR_W−1
- `oBusy` out 1: high from the accepted start until the done pulse, inclusive
- `oDone` out 1: one-cycle pulse after the last handshake
- `oTotal` out CDF_W: final CDF, held from done until the next start

## Operation
- Reset: every register is 0, including `oReadAddr`, `oValid`, `oBusy`, `oDone`, `oTotal`, the CDF accumulator, FIFO occupancy and the in-flight flag.
- States:
  - IDLE → SWEEP on `iStart`. Entering SWEEP clears the address counter and the accumulator.
  - SWEEP → DRAIN after the read for the last bin is issued.
  - DRAIN → DONE when the last beat handshakes.
  - DONE → IDLE after one cycle, with `oDone`=1 and `oTotal` updated.
- Read issue (SWEEP only): a read is issued in cycle c when FIFO occupancy plus in-flight count < 2. An issued read captures `iDataIn` in cycle c+1 as the count for `oReadAddr(c)`. The address then increments. It does not wrap; the sweep ends at the top bin.
- Capture: `cdf = acc + iDataIn` in CDF_W-bit unsigned arithmetic, with no saturation. `acc <= cdf`. {bin, count, cdf, last} is pushed into a 2-entry FIFO.
- Output: the FIFO head drives `oBin`/`oCount`/`oCdf`/`oLast`. `oValid` equals FIFO non-empty. Handshake is `oValid & iReady`.
- Once `oValid` is asserted, payload stays stable until the handshake. `iReady` may toggle freely.
- Simultaneous push and pop is allowed, and occupancy is unchanged.
- `iAbort` has priority over everything except reset:
  - The next cycle is IDLE with FIFO empty, in-flight cleared, `oValid`=0 and `oBusy`=0.
  - No `oDone` pulse is produced and `oTotal` is unchanged.
- `iStart` while busy is ignored. `iStart` and `iAbort` in the same IDLE cycle: abort wins and the block stays IDLE.
- Asynchronous reset mid-sweep returns the block to the reset state immediately.

## Timing
- `iStart` sampled at edge 0 → `oReadAddr`=0 with first issue in cycle 1 → capture in cycle 2 → `oValid` in cycle 3.
- With `iReady` held high: one beat per cycle; the last beat is in cycle 258, `oDone` in cycle 259, `oBusy` low in cycle 260.
- Sustained throughput is 1 beat/cycle. With `iReady` low, at most 2 beats are buffered and issue stalls.
- The RAM must not be written while `oBusy`=1 (system interlock; not checked here).

## Configuration
- `HIST_PEAK_EN` defined: adds outputs `oPeakBin` (ADDR_W) and `oPeakCount` (DATA_W).
  - These hold the highest-count bin of the last completed sweep; ties go to the lowest bin.
  - They update in the DONE cycle, reset to 0, and are unchanged on abort.
- `HIST_PEAK_EN` undefined: the ports and comparator logic are absent.

## Structure
- Package `hist_pkg`: ADDR_W/DATA_W/CDF_W defaults, state enum (IDLE, SWEEP, DRAIN, DONE), and the beat struct {bin, count, cdf, last}.
- Sub-module `hist_skid_fifo`: 2-entry register FIFO carrying the beat struct, exposing push, pop and occupancy.

## Test plan
- Sweep with RAM preloaded to count = bin index, `iReady`=1:
  - 256 beats; bin 255 has `oCount`=255 and `oCdf`=32640, with `oLast`=1.
  - `oTotal`=32640.
  - First `oValid` 3 cycles after start; `oDone` in cycle 259.
- All bins 0xFFFFF: final `oCdf` = 256×1048575 = 268435200, no overflow in 28 bits.
- Backpressure: `iReady` random 30% duty.
  - Payload stable while stalled.
  - No beat lost or duplicated.
  - In-flight plus occupancy never exceeds 2.
- `iAbort` asserted at beat 100:
  - `oValid`=0 and `oBusy`=0 the next cycle.
  - No `oDone`; `oTotal` keeps its previous value.
  - A new start then produces a full 256-beat sweep.
- `iStart` pulsed during SWEEP is ignored. `iRst_n` asserted mid-sweep zeroes all outputs asynchronously.
- With `HIST_PEAK_EN`: bins 17 and 200 both hold 5000 and all others are smaller → `oPeakBin`=17, `oPeakCount`=5000.
